// File: rtl/fft_drain_pkg.sv
// Shared state encoding and default widths for the FFT frame drain.
package fft_drain_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_GAP    = 2'd2
  } state_t;

  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_LEN_WIDTH  = 12;
  localparam int DEF_GAP_WIDTH  = 8;
  localparam int DEF_FCNT_WIDTH = 16;

endpackage

// File: rtl/fft_frame_drain.sv
// Drains FRAME_LEN words per frame from a show-ahead FIFO into a registered valid/ready stream.
// Define FFT_DRAIN_STATS_EN to add saturating underrun_cnt / stall_cnt outputs.
module fft_frame_drain
  import fft_drain_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH,
  parameter int GAP_WIDTH  = DEF_GAP_WIDTH,
  parameter int FCNT_WIDTH = DEF_FCNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  cont,
  input  logic                  abort,
  input  logic [LEN_WIDTH-1:0]  frame_len,
  input  logic [GAP_WIDTH-1:0]  gap_cycles,
  output logic                  rd_en,
  input  logic                  rd_vld,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_sop,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done,
  output logic [FCNT_WIDTH-1:0] frame_cnt
`ifdef FFT_DRAIN_STATS_EN
  ,
  output logic [15:0]           underrun_cnt,
  output logic [15:0]           stall_cnt
`endif
);

  state_t                state_q, state_d;
  logic [LEN_WIDTH-1:0]  words_left_q, words_left_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [GAP_WIDTH-1:0]  gap_q, gap_d;
  logic [GAP_WIDTH-1:0]  gap_cnt_q, gap_cnt_d;

  logic                  m_valid_q;
  logic [DATA_WIDTH-1:0] m_data_q;
  logic                  m_sop_q;
  logic                  m_last_q;
  logic                  done_q;
  logic [FCNT_WIDTH-1:0] frame_cnt_q;

  logic                  out_free;
  logic                  rd_en_c;
  logic                  pop;
  logic                  start_ok;

  assign out_free = !m_valid_q || m_ready;
  // abort also blocks a pop in its own cycle so nothing new enters the output register
  assign rd_en_c  = (state_q == ST_STREAM) && (words_left_q != '0) && out_free && !abort;
  assign pop      = rd_en_c && rd_vld;
  assign start_ok = (state_q == ST_IDLE) && start && (frame_len != '0) && !abort;

  always_comb begin
    state_d      = state_q;
    words_left_d = words_left_q;
    len_d        = len_q;
    gap_d        = gap_q;
    gap_cnt_d    = gap_cnt_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_ok) begin
            state_d      = ST_STREAM;
            len_d        = frame_len;
            gap_d        = gap_cycles;
            words_left_d = frame_len;
          end
        end
        ST_STREAM: begin
          if (pop) begin
            if (words_left_q == LEN_WIDTH'(1)) begin
              words_left_d = cont ? len_q : '0;
              if (cont && (gap_q != '0)) begin
                state_d   = ST_GAP;
                gap_cnt_d = gap_q;
              end else if (!cont) begin
                state_d = ST_IDLE;
              end
            end else begin
              words_left_d = words_left_q - 1'b1;
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt_q == GAP_WIDTH'(1)) begin
            state_d = ST_STREAM;
          end else begin
            gap_cnt_d = gap_cnt_q - 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      words_left_q <= '0;
      len_q        <= '0;
      gap_q        <= '0;
      gap_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      words_left_q <= words_left_d;
      len_q        <= len_d;
      gap_q        <= gap_d;
      gap_cnt_q    <= gap_cnt_d;
    end
  end

  // Output register: a pop always wins; otherwise the word leaves on m_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_sop_q     <= 1'b0;
      m_last_q    <= 1'b0;
      done_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      if (pop) begin
        m_valid_q <= 1'b1;
        m_data_q  <= rd_data;
        m_sop_q   <= (words_left_q == len_q);
        m_last_q  <= (words_left_q == LEN_WIDTH'(1));
      end else if (m_ready) begin
        m_valid_q <= 1'b0;
      end
      done_q <= m_valid_q && m_ready && m_last_q;
      if (m_valid_q && m_ready && m_last_q) begin
        frame_cnt_q <= frame_cnt_q + 1'b1;
      end
    end
  end

`ifdef FFT_DRAIN_STATS_EN
  logic [15:0] underrun_q;
  logic [15:0] stall_q;
  logic        underrun_evt;

  assign underrun_evt = (state_q == ST_STREAM) && (words_left_q != '0) && out_free && !rd_vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underrun_q <= '0;
      stall_q    <= '0;
    end else if (start_ok) begin
      underrun_q <= '0;
      stall_q    <= '0;
    end else begin
      if (underrun_evt && (underrun_q != 16'hFFFF)) underrun_q <= underrun_q + 1'b1;
      if (m_valid_q && !m_ready && (stall_q != 16'hFFFF)) stall_q <= stall_q + 1'b1;
    end
  end

  assign underrun_cnt = underrun_q;
  assign stall_cnt    = stall_q;
`endif

  assign rd_en     = rd_en_c;
  assign m_valid   = m_valid_q;
  assign m_data    = m_data_q;
  assign m_sop     = m_sop_q;
  assign m_last    = m_last_q;
  assign busy      = (state_q != ST_IDLE) || m_valid_q;
  assign done      = done_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_fft_frame_drain.sv
// Scoreboard bench for fft_frame_drain: a show-ahead FIFO model feeds the DUT and
// every word accepted downstream is compared against the queue filled at load time.
module tb_fft_frame_drain;
  localparam int DW = 64;
  localparam int LW = 12;
  localparam int GW = 8;
  localparam int FW = 16;

  logic          clk, rst, start, cont, abort;
  logic [LW-1:0] frame_len;
  logic [GW-1:0] gap_cycles;
  logic          rd_en, rd_vld;
  logic [DW-1:0] rd_data, m_data;
  logic          m_valid, m_ready, m_sop, m_last, busy, done;
  logic [FW-1:0] frame_cnt;
`ifdef FFT_DRAIN_STATS_EN
  logic [15:0]   underrun_cnt, stall_cnt;
`endif

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sop;
    logic          last;
  } exp_t;

  exp_t          exp_q[$];
  int            pop_cyc[$];
  logic [DW-1:0] fifo_mem [0:1023];
  int            head, tail;
  logic          vld_en;
  int            errors, checks, pops, done_count, cyc, run, max_run;

  fft_frame_drain #(
    .DATA_WIDTH(DW), .LEN_WIDTH(LW), .GAP_WIDTH(GW), .FCNT_WIDTH(FW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cont(cont), .abort(abort),
    .frame_len(frame_len), .gap_cycles(gap_cycles),
    .rd_en(rd_en), .rd_vld(rd_vld), .rd_data(rd_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_sop(m_sop), .m_last(m_last), .busy(busy), .done(done),
    .frame_cnt(frame_cnt)
`ifdef FFT_DRAIN_STATS_EN
    , .underrun_cnt(underrun_cnt), .stall_cnt(stall_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Show-ahead FIFO model
  assign rd_vld  = vld_en && (head != tail);
  assign rd_data = fifo_mem[head[9:0]];
  always @(posedge clk) if (rd_en && rd_vld) head <= head + 1;

  // Monitor / scoreboard, sampled on the falling edge
  initial forever begin
    exp_t e;
    @(negedge clk);
    cyc++;
    if (!rst) begin
      if (rd_en && rd_vld) begin
        pops++;
        pop_cyc.push_back(cyc);
      end
      if (m_valid) begin
        run++;
        if (run > max_run) max_run = run;
      end else run = 0;
      if (m_valid && !m_ready) begin
        checks++;
        if (rd_en !== 1'b0) begin
          errors++;
          $display("FAIL rd_en_while_stalled: rd_en=%0b required 0", rd_en);
        end
      end
      if (m_valid && m_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word: data=%h sop=%0b last=%0b, none expected", m_data, m_sop, m_last);
        end else begin
          e = exp_q.pop_front();
          if ({m_data, m_sop, m_last} !== {e.data, e.sop, e.last}) begin
            errors++;
            $display("FAIL word: got %h/%0b/%0b required %h/%0b/%0b",
                     m_data, m_sop, m_last, e.data, e.sop, e.last);
          end else begin
            $display("word data=%h sop=%0b last=%0b", m_data, m_sop, m_last);
          end
        end
      end
      if (done) done_count++;
    end
  end

  task automatic push_word(input logic sop, input logic last);
    logic [DW-1:0] d;
    d = {$urandom, $urandom};
    fifo_mem[tail[9:0]] = d;
    tail++;
    exp_q.push_back({d, sop, last});
  endtask

  task automatic load_frame(input int len);
    for (int i = 0; i < len; i++) push_word(i == 0, i == len - 1);
  endtask

  task automatic pulse_start(input int len, input int gap);
    @(posedge clk); #1;
    frame_len  = LW'(len);
    gap_cycles = GW'(gap);
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int limit, input string name);
    int n = 0;
    while (done_count < target && n < limit) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done_count < target) begin
      errors++;
      $display("FAIL %s_timeout: done_count=%0d required %0d", name, done_count, target);
    end
  endtask

  task automatic wait_pops(input int target, input int limit, input string name);
    int n = 0;
    while (pops < target && n < limit) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (pops < target) begin
      errors++;
      $display("FAIL %s_pop_timeout: pops=%0d required %0d", name, pops, target);
    end
  endtask

  task automatic test_reset();
    int p0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({rd_en, m_valid, m_sop, m_last, busy, done} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b required 000000", {rd_en, m_valid, m_sop, m_last, busy, done});
    end
    checks++;
    if (m_data !== '0 || frame_cnt !== '0) begin
      errors++;
      $display("FAIL reset_regs: m_data=%h frame_cnt=%0d required 0/0", m_data, frame_cnt);
    end
    rst = 1'b0;
    p0 = pops;
    pulse_start(0, 0);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || pops !== p0) begin
      errors++;
      $display("FAIL zero_len_start: busy=%0b pops=%0d required 0/%0d", busy, pops, p0);
    end
  endtask

  task automatic test_single();
    int p0;
    p0 = pops; run = 0; max_run = 0;
    load_frame(8);
    pulse_start(8, 0);
    wait_done(1, 60, "single");
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (pops - p0 !== 8) begin errors++; $display("FAIL single_pops: got %0d required 8", pops - p0); end
    checks++;
    if (max_run !== 8) begin errors++; $display("FAIL single_run: got %0d required 8", max_run); end
    checks++;
    if (done_count !== 1) begin errors++; $display("FAIL single_done: got %0d required 1", done_count); end
    checks++;
    if (frame_cnt !== 16'd1) begin errors++; $display("FAIL single_fcnt: got %0d required 1", frame_cnt); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL single_busy: got %0b required 0", busy); end
    checks++;
    if (exp_q.size() !== 0) begin errors++; $display("FAIL single_left: got %0d required 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    int p0, n;
    p0 = pops; n = 0;
    load_frame(12);
    pulse_start(12, 0);
    while (done_count < 2 && n < 100) begin
      @(posedge clk); #1;
      m_ready = ~m_ready;
      n++;
    end
    m_ready = 1'b1;
    checks++;
    if (done_count < 2) begin errors++; $display("FAIL bp_timeout: done_count=%0d required 2", done_count); end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (pops - p0 !== 12) begin errors++; $display("FAIL bp_pops: got %0d required 12", pops - p0); end
    checks++;
    if (frame_cnt !== 16'd2) begin errors++; $display("FAIL bp_fcnt: got %0d required 2", frame_cnt); end
    checks++;
    if (exp_q.size() !== 0) begin errors++; $display("FAIL bp_left: got %0d required 0", exp_q.size()); end
  endtask

  task automatic test_underrun();
    int p0;
    p0 = pops;
    load_frame(16);
    pulse_start(16, 0);
    wait_pops(p0 + 6, 40, "underrun");
    @(posedge clk); #1;
    vld_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vld_en = 1'b1;
    wait_done(3, 60, "underrun");
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (pops - p0 !== 16) begin errors++; $display("FAIL underrun_pops: got %0d required 16", pops - p0); end
    checks++;
    if (frame_cnt !== 16'd3) begin errors++; $display("FAIL underrun_fcnt: got %0d required 3", frame_cnt); end
    checks++;
    if (exp_q.size() !== 0) begin errors++; $display("FAIL underrun_left: got %0d required 0", exp_q.size()); end
`ifdef FFT_DRAIN_STATS_EN
    checks++;
    if (underrun_cnt !== 16'd3) begin errors++; $display("FAIL underrun_cnt: got %0d required 3", underrun_cnt); end
    checks++;
    if (stall_cnt !== 16'd0) begin errors++; $display("FAIL stall_cnt: got %0d required 0", stall_cnt); end
`endif
  endtask

  task automatic test_continuous();
    int d0, want;
    d0 = done_count;
    pop_cyc.delete();
    load_frame(4); load_frame(4); load_frame(4);
    cont = 1'b1;
    pulse_start(4, 5);
    wait_done(d0 + 2, 80, "cont2");
    @(posedge clk); #1;
    cont = 1'b0;
    wait_done(d0 + 3, 80, "cont3");
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (pop_cyc.size() !== 12) begin
      errors++;
      $display("FAIL cont_pops: got %0d required 12", pop_cyc.size());
    end else begin
      for (int i = 1; i < 12; i++) begin
        want = (i % 4 == 0) ? 6 : 1;
        checks++;
        if (pop_cyc[i] - pop_cyc[i-1] !== want) begin
          errors++;
          $display("FAIL cont_spacing[%0d]: got %0d required %0d", i, pop_cyc[i] - pop_cyc[i-1], want);
        end
      end
    end
    checks++;
    if (frame_cnt !== 16'd6) begin errors++; $display("FAIL cont_fcnt: got %0d required 6", frame_cnt); end
    checks++;
    if (busy !== 1'b0 || done_count !== d0 + 3) begin
      errors++;
      $display("FAIL cont_end: busy=%0b done=%0d required 0/%0d", busy, done_count, d0 + 3);
    end
  endtask

  task automatic test_abort();
    int p0, d0;
    p0 = pops; d0 = done_count;
    push_word(1'b1, 1'b0); push_word(1'b0, 1'b0); push_word(1'b0, 1'b0);
    pulse_start(10, 0);
    wait_pops(p0 + 3, 40, "abort");
    repeat (3) @(posedge clk);
    #1;
    m_ready = 1'b0;
    push_word(1'b0, 1'b0);
    @(posedge clk); #1;
    abort = 1'b1;
    for (int i = 0; i < 2; i++) begin
      fifo_mem[tail[9:0]] = {$urandom, $urandom};
      tail++;
    end
    @(posedge clk); #1;
    abort = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (pops - p0 !== 4) begin errors++; $display("FAIL abort_pops: got %0d required 4", pops - p0); end
    checks++;
    if (busy !== 1'b1 || m_valid !== 1'b1) begin
      errors++;
      $display("FAIL abort_hold: busy=%0b m_valid=%0b required 1/1", busy, m_valid);
    end
    m_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_release: busy=%0b m_valid=%0b required 0/0", busy, m_valid);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (pops - p0 !== 4 || done_count !== d0) begin
      errors++;
      $display("FAIL abort_after: pops=%0d done=%0d required 4/%0d", pops - p0, done_count, d0);
    end
    checks++;
    if (frame_cnt !== 16'd6 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL abort_fcnt: fcnt=%0d left=%0d required 6/0", frame_cnt, exp_q.size());
    end
    tail = head;
    start = 1'b1; abort = 1'b1; frame_len = 12'd5;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_wins: busy=%0b required 0", busy); end
  endtask

  task automatic test_rst_midframe();
    int p0, d0;
    p0 = pops;
    load_frame(8);
    pulse_start(8, 0);
    wait_pops(p0 + 3, 40, "rst");
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({rd_en, m_valid, m_sop, m_last, busy, done} !== 6'b0) begin
      errors++;
      $display("FAIL rst_flags: got %b required 000000", {rd_en, m_valid, m_sop, m_last, busy, done});
    end
    checks++;
    if (m_data !== '0 || frame_cnt !== '0) begin
      errors++;
      $display("FAIL rst_regs: m_data=%h frame_cnt=%0d required 0/0", m_data, frame_cnt);
    end
    exp_q.delete();
    @(posedge clk); #1;
    tail = head;
    rst  = 1'b0;
    d0 = done_count;
    load_frame(1);
    pulse_start(1, 0);
    wait_done(d0 + 1, 30, "len1");
    @(posedge clk); #1;
    checks++;
    if (frame_cnt !== 16'd1 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL len1: fcnt=%0d left=%0d required 1/0", frame_cnt, exp_q.size());
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cont = 1'b0; abort = 1'b0;
    frame_len = '0; gap_cycles = '0; m_ready = 1'b0; vld_en = 1'b0;
    errors = 0; checks = 0; pops = 0; done_count = 0; cyc = 0; run = 0; max_run = 0;
    tail = 0;
    test_reset();
    m_ready = 1'b1;
    vld_en  = 1'b1;
    test_single();
    test_backpressure();
    test_underrun();
    test_continuous();
    test_abort();
    test_rst_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
